// File: rtl/mem_lsu_if.sv
// mem_lsu_if: data-memory bus between the load/store unit and data memory.
//   master (LSU)    : drives dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata;
//                     receives dmemRdata, dmemAck.
//   slave  (memory) : the mirror image.
//   dmemReq is held until the one-cycle dmemAck strobe; dmemRdata is valid
//   only in the dmemAck cycle.
interface mem_lsu_if;
   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = 4;

   logic            dmemReq;
   logic            dmemWe;
   logic [XLEN-1:0] dmemAddr;
   logic [BE_W-1:0] dmemBe;
   logic [XLEN-1:0] dmemWdata;
   logic [XLEN-1:0] dmemRdata;
   logic            dmemAck;

   modport master (
      output dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
      input  dmemRdata, dmemAck
   );

   modport slave (
      input  dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
      output dmemRdata, dmemAck
   );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit for an RV32I pipeline.
//   clk, rst       : clock, synchronous active-high reset
//   memRead        : MEM-stage instruction is a load
//   memMEMWrite    : MEM-stage instruction is a store (wins over memRead)
//   memFunct3      : funct3 of the load/store
//   memResult      : byte address
//   memMEMWdata    : store source value
//   dmem           : data-memory bus (master side)
//   lsuStall       : combinational freeze of PC/IF_ID/ID_EX/EX_MEM
//   lsuValid       : one-cycle pulse, access finished
//   lsuRdata       : extended load result, held until next lsuValid
//   lsuFault       : one-cycle pulse on misaligned/illegal access or timeout
module mem_lsu (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memMEMWrite,
   input  logic [2:0]        memFunct3,
   input  logic [31:0]       memResult,
   input  logic [31:0]       memMEMWdata,
   mem_lsu_if.master         dmem,
   output logic              lsuStall,
   output logic              lsuValid,
   output logic [31:0]       lsuRdata,
   output logic              lsuFault
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned BE_W  = 4;
   localparam int unsigned CNT_W = 8;
   // Counter value in the 255th BUSY cycle (counter is 0 in the first).
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(254);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              valid_q, valid_d;
   logic              fault_q, fault_d;

   logic              access_c;
   logic              legal_c;
   logic              aligned_c;
   logic [BE_W-1:0]   be_c;
   logic [XLEN-1:0]   wdata_c;
   logic [7:0]        byte_c;
   logic [15:0]       half_c;
   logic [XLEN-1:0]   load_ext_c;

   // Decode the MEM-stage request: legality, alignment, lanes.
   always_comb begin
      access_c  = memRead | memMEMWrite;
      legal_c   = 1'b0;
      aligned_c = 1'b1;
      be_c      = 4'b1111;
      wdata_c   = '0;
      if (memMEMWrite) begin
         legal_c = memFunct3 inside {3'b000, 3'b001, 3'b010};
      end else begin
         legal_c = memFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      case (memFunct3[1:0])
         2'b01:   aligned_c = ~memResult[0];
         2'b10:   aligned_c = (memResult[1:0] == 2'b00);
         default: aligned_c = 1'b1;
      endcase
      if (memMEMWrite) begin
         case (memFunct3[1:0])
            2'b00: begin
               be_c    = 4'b0001 << memResult[1:0];
               wdata_c = {4{memMEMWdata[7:0]}};
            end
            2'b01: begin
               be_c    = 4'b0011 << {memResult[1], 1'b0};
               wdata_c = {2{memMEMWdata[15:0]}};
            end
            default: begin
               be_c    = 4'b1111;
               wdata_c = memMEMWdata;
            end
         endcase
      end
   end

   // Select and extend the load result from the returned word.
   always_comb begin
      case (off_q)
         2'd0:    byte_c = dmem.dmemRdata[7:0];
         2'd1:    byte_c = dmem.dmemRdata[15:8];
         2'd2:    byte_c = dmem.dmemRdata[23:16];
         default: byte_c = dmem.dmemRdata[31:24];
      endcase
      half_c = off_q[1] ? dmem.dmemRdata[31:16] : dmem.dmemRdata[15:0];
      case (funct3_q)
         3'b000:  load_ext_c = {{24{byte_c[7]}}, byte_c};
         3'b001:  load_ext_c = {{16{half_c[15]}}, half_c};
         3'b100:  load_ext_c = {24'd0, byte_c};
         3'b101:  load_ext_c = {16'd0, half_c};
         default: load_ext_c = dmem.dmemRdata;
      endcase
   end

   // Next-state and combinational outputs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      rdata_d  = rdata_q;
      fault_d  = 1'b0;
      lsuStall = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access_c) begin
               if (legal_c && aligned_c) begin
                  lsuStall = 1'b1;
                  state_d  = S_BUSY;
                  cnt_d    = '0;
                  we_d     = memMEMWrite;
                  addr_d   = {memResult[31:2], 2'b00};
                  be_d     = be_c;
                  wdata_d  = wdata_c;
                  funct3_d = memFunct3;
                  off_d    = memResult[1:0];
               end else begin
                  fault_d = 1'b1;
               end
            end
         end
         S_BUSY: begin
            lsuStall = 1'b1;
            if (dmem.dmemAck) begin
               state_d = S_DONE;
               if (!we_q) begin
                  rdata_d = load_ext_c;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               fault_d = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Request and completion pulse are registered decodes of the next state.
      req_d   = (state_d == S_BUSY);
      valid_d = (state_d == S_DONE);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         off_q    <= '0;
         rdata_q  <= '0;
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         rdata_q  <= rdata_d;
         valid_q  <= valid_d;
         fault_q  <= fault_d;
      end
   end

   assign dmem.dmemReq   = req_q;
   assign dmem.dmemWe    = we_q;
   assign dmem.dmemAddr  = addr_q;
   assign dmem.dmemBe    = be_q;
   assign dmem.dmemWdata = wdata_q;
   assign lsuValid       = valid_q;
   assign lsuRdata       = rdata_q;
   assign lsuFault       = fault_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu.
module tb_mem_lsu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        memRead = 1'b0;
   logic        memMEMWrite = 1'b0;
   logic [2:0]  memFunct3 = 3'b000;
   logic [31:0] memResult = '0;
   logic [31:0] memMEMWdata = '0;
   logic        lsuStall;
   logic        lsuValid;
   logic [31:0] lsuRdata;
   logic        lsuFault;

   int n_cmp  = 0;
   int n_fail = 0;

   // Observations of the last access, filled by run_access.
   int          obs_lat, obs_req_cycles, obs_fault_cycles, obs_first_fault;
   logic        obs_stall0, obs_we, obs_unstable, obs_stall_bad;
   logic        obs_fault_at_valid, obs_valid_after;
   logic [31:0] obs_addr, obs_wdata, obs_rdata;
   logic [3:0]  obs_be;

   mem_lsu_if dmem ();

   mem_lsu dut (
      .clk         (clk),
      .rst         (rst),
      .memRead     (memRead),
      .memMEMWrite (memMEMWrite),
      .memFunct3   (memFunct3),
      .memResult   (memResult),
      .memMEMWdata (memMEMWdata),
      .dmem        (dmem),
      .lsuStall    (lsuStall),
      .lsuValid    (lsuValid),
      .lsuRdata    (lsuRdata),
      .lsuFault    (lsuFault)
   );

   always #5 clk = ~clk;

   // Present one request for a single cycle, act as memory acking the
   // (ack_after+1)-th request cycle (never if negative), record what happens.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdv, input int ack_after,
                             input int max_cycles);
      memRead = rd; memMEMWrite = wr; memFunct3 = f3; memResult = addr; memMEMWdata = wd;
      #1 obs_stall0 = lsuStall;
      obs_lat = -1; obs_req_cycles = 0; obs_fault_cycles = 0; obs_first_fault = -1;
      obs_unstable = 1'b0; obs_stall_bad = 1'b0; obs_fault_at_valid = 1'b0;
      obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0; obs_rdata = '0;
      for (int c = 1; c <= max_cycles; c++) begin
         @(posedge clk); #1;
         dmem.dmemAck = 1'b0;
         dmem.dmemRdata = 32'h5A5A_5A5A;
         if (c == 1) begin
            memRead = 1'b0; memMEMWrite = 1'b0; memFunct3 = '0; memResult = '0; memMEMWdata = '0;
         end
         if (lsuStall !== dmem.dmemReq) obs_stall_bad = 1'b1;
         if (lsuFault === 1'b1) begin
            obs_fault_cycles++;
            if (obs_first_fault < 0) obs_first_fault = c;
         end
         if (dmem.dmemReq === 1'b1) begin
            if (obs_req_cycles == 0) begin
               obs_addr = dmem.dmemAddr; obs_be = dmem.dmemBe;
               obs_we = dmem.dmemWe; obs_wdata = dmem.dmemWdata;
            end else if (obs_addr !== dmem.dmemAddr || obs_be !== dmem.dmemBe ||
                         obs_we !== dmem.dmemWe || obs_wdata !== dmem.dmemWdata) begin
               obs_unstable = 1'b1;
            end
            obs_req_cycles++;
            if (obs_req_cycles == ack_after + 1) begin
               dmem.dmemAck = 1'b1;
               dmem.dmemRdata = rdv;
            end
         end
         if (lsuValid === 1'b1) begin
            obs_lat = c;
            obs_rdata = lsuRdata;
            obs_fault_at_valid = lsuFault;
            break;
         end
      end
      @(posedge clk); #1;
      dmem.dmemAck = 1'b0;
      obs_valid_after = lsuValid;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (dmem.dmemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dmem.dmemReq); end
      n_cmp++; if (dmem.dmemWe !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", dmem.dmemWe); end
      n_cmp++; if (dmem.dmemAddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", dmem.dmemAddr); end
      n_cmp++; if (dmem.dmemBe !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %b want 0000", dmem.dmemBe); end
      n_cmp++; if (dmem.dmemWdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", dmem.dmemWdata); end
      n_cmp++; if (lsuStall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", lsuStall); end
      n_cmp++; if (lsuValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", lsuValid); end
      n_cmp++; if (lsuFault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", lsuFault); end
      n_cmp++; if (lsuRdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", lsuRdata); end
      rst = 1'b0;
   endtask

   task automatic test_lw();
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 20);
      n_cmp++; if (obs_stall0 !== 1'b1) begin n_fail++; $display("FAIL lw_stall_detect: got %b want 1", obs_stall0); end
      n_cmp++; if (obs_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", obs_addr); end
      n_cmp++; if (obs_be !== 4'b1111) begin n_fail++; $display("FAIL lw_be: got %b want 1111", obs_be); end
      n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b want 0", obs_we); end
      n_cmp++; if (obs_lat != 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", obs_lat); end
      n_cmp++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", obs_rdata); end
      n_cmp++; if (obs_req_cycles != 2) begin n_fail++; $display("FAIL lw_req_cycles: got %0d want 2", obs_req_cycles); end
      n_cmp++; if (obs_valid_after !== 1'b0) begin n_fail++; $display("FAIL lw_valid_pulse: got %b want 0", obs_valid_after); end
      n_cmp++; if (obs_stall_bad !== 1'b0) begin n_fail++; $display("FAIL lw_stall_track: got %b want 0", obs_stall_bad); end
      n_cmp++; if (obs_fault_cycles != 0) begin n_fail++; $display("FAIL lw_fault: got %0d want 0", obs_fault_cycles); end
      n_cmp++; if (lsuRdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata_hold: got %h want deadbeef", lsuRdata); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3 [8]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001, 3'b101, 3'b010};
      logic [31:0] ad [8]  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100, 32'h100, 32'h104};
      logic [31:0] rv [8]  = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                               32'h1234_5678, 32'h1234_F678, 32'h1234_F678, 32'hA5A5_5A5A};
      logic [31:0] ex [8]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF,
                               32'h0000_0056, 32'hFFFF_F678, 32'h0000_F678, 32'hA5A5_5A5A};
      for (int i = 0; i < 8; i++) begin
         run_access(1'b1, 1'b0, f3[i], ad[i], 32'h0, rv[i], 0, 20);
         n_cmp++; if (obs_rdata !== ex[i]) begin n_fail++; $display("FAIL load_ext[%0d]: got %h want %h", i, obs_rdata, ex[i]); end
         n_cmp++; if (obs_addr !== (ad[i] & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL load_addr[%0d]: got %h want %h", i, obs_addr, ad[i] & 32'hFFFF_FFFC); end
         n_cmp++; if (obs_lat != 2) begin n_fail++; $display("FAIL load_min_latency[%0d]: got %0d want 2", i, obs_lat); end
      end
   endtask

   task automatic test_store();
      logic [2:0]  f3 [5] = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b010};
      logic [31:0] ad [5] = '{32'h206, 32'h101, 32'h103, 32'h200, 32'h208};
      logic [31:0] wd [5] = '{32'h1234_ABCD, 32'hFFFF_FF3C, 32'h0000_0011, 32'hCAFE_BABE, 32'hDEAD_BEEF};
      logic [3:0]  eb [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b0011, 4'b1111};
      logic [31:0] ew [5] = '{32'hABCD_ABCD, 32'h3C3C_3C3C, 32'h1111_1111, 32'hBABE_BABE, 32'hDEAD_BEEF};
      run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0BAD_F00D, 0, 20);
      for (int i = 0; i < 5; i++) begin
         run_access(1'b0, 1'b1, f3[i], ad[i], wd[i], 32'hFFFF_FFFF, 2, 20);
         n_cmp++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL st_we[%0d]: got %b want 1", i, obs_we); end
         n_cmp++; if (obs_be !== eb[i]) begin n_fail++; $display("FAIL st_be[%0d]: got %b want %b", i, obs_be, eb[i]); end
         n_cmp++; if (obs_wdata !== ew[i]) begin n_fail++; $display("FAIL st_wdata[%0d]: got %h want %h", i, obs_wdata, ew[i]); end
         n_cmp++; if (obs_req_cycles != 3 || obs_unstable !== 1'b0) begin n_fail++; $display("FAIL st_req_hold[%0d]: got %0d/%b want 3/0", i, obs_req_cycles, obs_unstable); end
         n_cmp++; if (obs_lat != 4 || obs_stall_bad !== 1'b0) begin n_fail++; $display("FAIL st_stall[%0d]: got %0d/%b want 4/0", i, obs_lat, obs_stall_bad); end
         n_cmp++; if (obs_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL st_rdata_keep[%0d]: got %h want 0badf00d", i, obs_rdata); end
      end
      n_cmp++; if (dmem.dmemAddr !== 32'h208) begin n_fail++; $display("FAIL st_addr: got %h want 00000208", dmem.dmemAddr); end
   endtask

   task automatic test_both_high();
      run_access(1'b1, 1'b1, 3'b010, 32'h30C, 32'h0102_0304, 32'h7777_7777, 0, 20);
      n_cmp++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL both_we: got %b want 1", obs_we); end
      n_cmp++; if (obs_wdata !== 32'h0102_0304) begin n_fail++; $display("FAIL both_wdata: got %h want 01020304", obs_wdata); end
      n_cmp++; if (obs_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL both_rdata_keep: got %h want 0badf00d", obs_rdata); end
      run_access(1'b1, 1'b1, 3'b100, 32'h300, 32'h0, 32'h0, 0, 6);
      n_cmp++; if (obs_req_cycles != 0 || obs_fault_cycles != 1) begin n_fail++; $display("FAIL both_illegal: got req %0d fault %0d want 0/1", obs_req_cycles, obs_fault_cycles); end
   endtask

   task automatic test_misaligned();
      logic        rd [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [2:0]  f3 [8] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b011, 3'b110, 3'b100, 3'b111};
      logic [31:0] ad [8] = '{32'h101, 32'h103, 32'h102, 32'h201, 32'h100, 32'h100, 32'h100, 32'h0};
      for (int i = 0; i < 8; i++) begin
         run_access(rd[i], ~rd[i], f3[i], ad[i], 32'h1234_5678, 32'h0, 0, 5);
         n_cmp++; if (obs_req_cycles != 0) begin n_fail++; $display("FAIL bad_req[%0d]: got %0d want 0", i, obs_req_cycles); end
         n_cmp++; if (obs_fault_cycles != 1 || obs_first_fault != 1) begin n_fail++; $display("FAIL bad_fault[%0d]: got %0d at %0d want 1 at 1", i, obs_fault_cycles, obs_first_fault); end
         n_cmp++; if (obs_stall0 !== 1'b0) begin n_fail++; $display("FAIL bad_stall[%0d]: got %b want 0", i, obs_stall0); end
         n_cmp++; if (obs_lat != -1) begin n_fail++; $display("FAIL bad_valid[%0d]: got %0d want -1", i, obs_lat); end
      end
   endtask

   task automatic test_ignored_ack();
      run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h1122_3344, 0, 20);
      dmem.dmemAck = 1'b1; dmem.dmemRdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++; if (lsuValid !== 1'b0 || dmem.dmemReq !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got valid %b req %b want 0/0", lsuValid, dmem.dmemReq); end
      dmem.dmemAck = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (lsuRdata !== 32'h1122_3344 || lsuValid !== 1'b0) begin n_fail++; $display("FAIL idle_ack_rdata: got %h/%b want 11223344/0", lsuRdata, lsuValid); end
   endtask

   task automatic test_timeout();
      run_access(1'b1, 1'b0, 3'b000, 32'h55, 32'h0, 32'h0, -1, 300);
      n_cmp++; if (obs_req_cycles != 255) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 255", obs_req_cycles); end
      n_cmp++; if (obs_lat != 256) begin n_fail++; $display("FAIL to_latency: got %0d want 256", obs_lat); end
      n_cmp++; if (obs_fault_at_valid !== 1'b1 || obs_fault_cycles != 1) begin n_fail++; $display("FAIL to_fault: got %b/%0d want 1/1", obs_fault_at_valid, obs_fault_cycles); end
      n_cmp++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", obs_rdata); end
      n_cmp++; if (obs_stall_bad !== 1'b0 || obs_unstable !== 1'b0) begin n_fail++; $display("FAIL to_hold: got %b/%b want 0/0", obs_stall_bad, obs_unstable); end
   endtask

   task automatic test_rst_busy();
      int valid_seen = 0;
      run_access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'hAAAA_5555, 0, 20);
      memRead = 1'b1; memFunct3 = 3'b010; memResult = 32'h100;
      @(posedge clk); #1;
      memRead = 1'b0; memResult = '0;
      n_cmp++; if (dmem.dmemReq !== 1'b1) begin n_fail++; $display("FAIL rb_req_start: got %b want 1", dmem.dmemReq); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      dmem.dmemAck = 1'b1; dmem.dmemRdata = 32'h7777_7777;
      n_cmp++; if (dmem.dmemReq !== 1'b0 || lsuStall !== 1'b0) begin n_fail++; $display("FAIL rb_abandon: got req %b stall %b want 0/0", dmem.dmemReq, lsuStall); end
      n_cmp++; if (lsuRdata !== 32'h0) begin n_fail++; $display("FAIL rb_rdata: got %h want 0", lsuRdata); end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         dmem.dmemAck = 1'b0;
         if (lsuValid === 1'b1 || dmem.dmemReq === 1'b1) valid_seen++;
      end
      n_cmp++; if (valid_seen != 0) begin n_fail++; $display("FAIL rb_late_ack: got %0d want 0", valid_seen); end
      n_cmp++; if (lsuRdata !== 32'h0) begin n_fail++; $display("FAIL rb_rdata_after: got %h want 0", lsuRdata); end
   endtask

   initial begin
      dmem.dmemAck = 1'b0;
      dmem.dmemRdata = '0;
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_both_high();
      test_misaligned();
      test_ignored_ack();
      test_timeout();
      test_rst_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
